// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// game_timer : BCD mm:ss survival clock with start/pause/clear control,
//              terminal minute (DONE) and a sticky missing-tick watchdog.
// Revision   : 1.0
// ============================================================================
module game_timer #(
   parameter int MAX_MIN      = 59,
   parameter int TICK_TIMEOUT = 60000000,
   parameter int TW           = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       done,
   output logic       tick_fault
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0]    c_MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0]    c_MAX_ONES = 4'(MAX_MIN % 10);
   localparam logic [TW-1:0] c_TIMEOUT  = TW'(TICK_TIMEOUT);

   state_t        state_q, state_d;
   logic [3:0]    so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
   logic [TW-1:0] wd_q, wd_d;
   logic          fault_q, fault_d;
   logic          running_q, done_q;

   logic [3:0]    w_so_inc, w_st_inc, w_mo_inc, w_mt_inc;
   logic          w_at_max;

   // BCD ripple increment of the current value
   always_comb begin
      w_so_inc = so_q + 4'd1;
      w_st_inc = st_q;
      w_mo_inc = mo_q;
      w_mt_inc = mt_q;
      if (so_q == 4'd9) begin
         w_so_inc = 4'd0;
         w_st_inc = st_q + 4'd1;
         if (st_q == 4'd5) begin
            w_st_inc = 4'd0;
            w_mo_inc = mo_q + 4'd1;
            if (mo_q == 4'd9) begin
               w_mo_inc = 4'd0;
               w_mt_inc = mt_q + 4'd1;
            end
         end
      end
   end

   assign w_at_max = (w_mt_inc == c_MAX_TENS) && (w_mo_inc == c_MAX_ONES) &&
                     (w_st_inc == 4'd5) && (w_so_inc == 4'd9);

   always_comb begin
      state_d = state_q;
      so_d    = so_q;
      st_d    = st_q;
      mo_d    = mo_q;
      mt_d    = mt_q;
      wd_d    = '0;
      fault_d = fault_q;
      if (clear) begin
         state_d = IDLE;
         so_d    = 4'd0;
         st_d    = 4'd0;
         mo_d    = 4'd0;
         mt_d    = 4'd0;
         fault_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) state_d = RUN;
            end
            RUN: begin
               if (tick) begin
                  so_d = w_so_inc;
                  st_d = w_st_inc;
                  mo_d = w_mo_inc;
                  mt_d = w_mt_inc;
                  if (w_at_max) state_d = DONE;
               end else if (wd_q != c_TIMEOUT) begin
                  wd_d = wd_q + TW'(1);
               end else begin
                  wd_d = wd_q;
               end
               // Reaching the terminal value wins over a simultaneous pause
               if (state_d == RUN && pause && !start) state_d = PAUSED;
            end
            PAUSED: begin
               if (start) state_d = RUN;
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase
         if (state_d != RUN) wd_d = '0;
         if (state_d == RUN && wd_d == c_TIMEOUT) fault_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         so_q      <= 4'd0;
         st_q      <= 4'd0;
         mo_q      <= 4'd0;
         mt_q      <= 4'd0;
         wd_q      <= '0;
         fault_q   <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         so_q      <= so_d;
         st_q      <= st_d;
         mo_q      <= mo_d;
         mt_q      <= mt_d;
         wd_q      <= wd_d;
         fault_q   <= fault_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
      end
   end

   assign sec_ones   = so_q;
   assign sec_tens   = st_q;
   assign min_ones   = mo_q;
   assign min_tens   = mt_q;
   assign running    = running_q;
   assign done       = done_q;
   assign tick_fault = fault_q;

endmodule
`default_nettype wire
